// File: rtl/anita3_pps_delay_trigger.sv
// PPS1 delayed trigger: fires a PULSE_LEN-cycle trig_o a programmable delay after each PPS,
// plus a missing-PPS watchdog. Optional period measurement enabled by PPS_PERIOD_MEAS_EN.
module anita3_pps_delay_trigger #(
  parameter int CNT_W     = 32,
  parameter int PULSE_LEN = 4,
  parameter int WDOG_CYC  = 34000000
) (
  input  logic             clk33_i,
  input  logic             rst_n_i,
  input  logic             pps_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] delay_i,
  output logic             trig_o,
  output logic             armed_o,
  output logic             skip_o,
  output logic             pps_lost_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o
);

  localparam int PLEN_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PLEN_W-1:0] PLEN_LAST = PLEN_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  WDOG      = CNT_W'(WDOG_CYC);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  dly, dly_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PLEN_W-1:0] plen, plen_nxt;
  logic [CNT_W-1:0]  since_cnt, since_nxt;

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      dly     <= '0;
      cnt     <= '0;
      plen    <= '0;
      trig_o  <= 1'b0;
      armed_o <= 1'b0;
      skip_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      dly     <= dly_nxt;
      cnt     <= cnt_nxt;
      plen    <= plen_nxt;
      trig_o  <= (state_nxt == FIRE);
      armed_o <= (state_nxt == COUNT);
      skip_o  <= en_i & pps_i & (state == FIRE);
    end
  end

  // A PPS outside FIRE (re)arms from scratch, so a PPS mid-COUNT abandons the pending trigger.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    cnt_nxt   = cnt;
    plen_nxt  = plen;
    if (!en_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      plen_nxt  = '0;
    end else if (pps_i && state != FIRE) begin
      dly_nxt   = delay_i;
      cnt_nxt   = '0;
      plen_nxt  = '0;
      state_nxt = (delay_i == '0) ? FIRE : COUNT;
    end else begin
      case (state)
        COUNT: begin
          if (cnt == dly - CNT_W'(1)) begin
            state_nxt = FIRE;
            plen_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        FIRE: begin
          if (plen == PLEN_LAST) state_nxt = IDLE;
          else                   plen_nxt  = plen + PLEN_W'(1);
        end
        IDLE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Watchdog counter saturates so a long PPS outage never wraps back to "healthy".
  always_comb begin
    if (pps_i)                  since_nxt = '0;
    else if (since_cnt >= WDOG) since_nxt = WDOG;
    else                        since_nxt = since_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      since_cnt  <= '0;
      pps_lost_o <= 1'b0;
    end else begin
      since_cnt  <= since_nxt;
      pps_lost_o <= (since_nxt >= WDOG);
    end
  end

`ifdef PPS_PERIOD_MEAS_EN
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      period_valid_o <= pps_i;
      if (pps_i) period_o <= since_cnt + CNT_W'(1);
    end
  end
`else
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif

endmodule
